truth_table_sweeper: RTL and testbench

Sequential controller that exhaustively exercises one 3-input combinational logic gate (one of the hex-named truth-table modules, e.g. 0x87). It drives all eight `{in1,in2,in3}` combinations in ascending order and holds each one for a programmable settling time. It samples the gate output per row, assembles the observed 8-bit truth table and compares it against an expected code. It sits between a test/characterisation sequencer and one gate instance.

---
 rtl/truth_table_sweeper.sv | 154 +++++++++++++++
 tb/tb_truth_table_sweeper.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
`timescale 1ns/1ps
// Purpose: sweeps {in1,in2,in3} 0..7 into one 3-input gate, captures its truth table and compares it to a code
//          (define TRUTH_TABLE_SWEEPER_MISMATCH_STOP_EN to end the sweep at the first mismatching row).
// Latency: 8*(SETTLE_CYCLES+1) busy cycles after start, then a one-cycle done; no backpressure, start ignored while busy.
module truth_table_sweeper #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] expected,
    output logic [2:0] dut_in,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] observed,
    output logic [2:0] first_fail
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam bit         ZERO_SETTLE = (SETTLE_CYCLES == 0);
    localparam logic [7:0] SETTLE_LAST = ZERO_SETTLE ? 8'd0 : 8'(SETTLE_CYCLES - 1);
    // With no settle time each row goes straight to its sample cycle.
    localparam logic [1:0] ROW_ENTRY   = ZERO_SETTLE ? S_SAMPLE : S_SETTLE;

    logic [1:0] state_q, state_d;
    logic [2:0] row_q, row_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] exp_q, exp_d;
    logic [7:0] acc_q, acc_d;
    logic       fail_seen_q, fail_seen_d;
    logic [2:0] fail_row_q, fail_row_d;
    logic       pass_q, pass_d;
    logic [7:0] observed_q, observed_d;
    logic [2:0] first_fail_q, first_fail_d;

    logic [2:0] bit_idx;
    logic [7:0] acc_new;
    logic       miss;
    logic       new_fail;
    logic       stop_now;

    // Row r maps to bit 7-r of the hex truth-table code.
    assign bit_idx = ~row_q;

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        cnt_d        = cnt_q;
        exp_d        = exp_q;
        acc_d        = acc_q;
        fail_seen_d  = fail_seen_q;
        fail_row_d   = fail_row_q;
        pass_d       = pass_q;
        observed_d   = observed_q;
        first_fail_d = first_fail_q;

        acc_new          = acc_q;
        acc_new[bit_idx] = dut_out;
        miss             = (dut_out != exp_q[bit_idx]);
        new_fail         = miss && !fail_seen_q;
`ifdef TRUTH_TABLE_SWEEPER_MISMATCH_STOP_EN
        stop_now         = new_fail;
`else
        stop_now         = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    exp_d        = expected;
                    acc_d        = 8'd0;
                    fail_seen_d  = 1'b0;
                    fail_row_d   = 3'd0;
                    pass_d       = 1'b0;
                    observed_d   = 8'd0;
                    first_fail_d = 3'd0;
                    row_d        = 3'd0;
                    cnt_d        = 8'd0;
                    state_d      = ROW_ENTRY;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                acc_d = acc_new;
                if (new_fail) begin
                    fail_seen_d = 1'b1;
                    fail_row_d  = row_q;
                end
                if (row_q == 3'd7 || stop_now) begin
                    // Results become visible together with done.
                    state_d      = S_FINISH;
                    observed_d   = acc_new;
                    pass_d       = (acc_new == exp_q);
                    first_fail_d = fail_seen_q ? fail_row_q : (miss ? row_q : 3'd0);
                end else begin
                    row_d   = row_q + 3'd1;
                    cnt_d   = 8'd0;
                    state_d = ROW_ENTRY;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            row_q        <= 3'd0;
            cnt_q        <= 8'd0;
            exp_q        <= 8'd0;
            acc_q        <= 8'd0;
            fail_seen_q  <= 1'b0;
            fail_row_q   <= 3'd0;
            pass_q       <= 1'b0;
            observed_q   <= 8'd0;
            first_fail_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            cnt_q        <= cnt_d;
            exp_q        <= exp_d;
            acc_q        <= acc_d;
            fail_seen_q  <= fail_seen_d;
            fail_row_q   <= fail_row_d;
            pass_q       <= pass_d;
            observed_q   <= observed_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign dut_in     = row_q;
    assign busy       = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    assign done       = (state_q == S_FINISH);
    assign pass       = pass_q;
    assign observed   = observed_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
`timescale 1ns/1ps
// Bench for truth_table_sweeper: two instances (settle 4 and settle 0) each driving a modelled gate;
// sweep results are queued at start and compared when done appears.
module tb_truth_table_sweeper;

    logic       clk;
    logic       rst;
    logic       start_a, start_b;
    logic [7:0] exp_a, exp_b;
    logic [2:0] dut_in_a, dut_in_b;
    logic       dut_out_a, dut_out_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [7:0] obs_a, obs_b;
    logic [2:0] ff_a, ff_b;
    logic [7:0] gate_a, gate_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] obs;
        logic       pass;
        logic [2:0] ff;
        int         done_cyc;
    } exp_t;

    exp_t sb_q[$];

    logic       sel_r;
    logic       cur_busy, cur_done, cur_pass;
    logic [7:0] cur_obs;
    logic [2:0] cur_ff, cur_in;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate models: output for row r is bit 7-r of the gate's hex code.
    assign dut_out_a = gate_a[~dut_in_a];
    assign dut_out_b = gate_b[~dut_in_b];

    assign cur_busy = sel_r ? busy_b   : busy_a;
    assign cur_done = sel_r ? done_b   : done_a;
    assign cur_pass = sel_r ? pass_b   : pass_a;
    assign cur_obs  = sel_r ? obs_b    : obs_a;
    assign cur_ff   = sel_r ? ff_b     : ff_a;
    assign cur_in   = sel_r ? dut_in_b : dut_in_a;

    truth_table_sweeper #(.SETTLE_CYCLES(4)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .expected(exp_a),
        .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .observed(obs_a), .first_fail(ff_a)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .expected(exp_b),
        .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .observed(obs_b), .first_fail(ff_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] gate, input logic [7:0] code, input int settle);
        exp_t       m;
        logic [7:0] diff;
        int         first;
        diff  = gate ^ code;
        first = -1;
        for (int r = 0; r < 8; r++) begin
            if (diff[7-r] && first < 0) first = r;
        end
        m.pass     = (first < 0);
        m.ff       = (first < 0) ? 3'd0 : 3'(first);
        m.obs      = gate;
        m.done_cyc = 8 * (settle + 1) + 1;
`ifdef TRUTH_TABLE_SWEEPER_MISMATCH_STOP_EN
        if (first >= 0) begin
            m.obs = 8'd0;
            for (int r = 0; r <= first; r++) m.obs[7-r] = gate[7-r];
            m.done_cyc = (first + 1) * (settle + 1) + 1;
        end
`endif
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full sweep; optionally re-asserts start (with a different code) mid-sweep.
    task automatic run_sweep(input bit sel, input logic [7:0] code, input bit poke);
        int   settle;
        int   cyc;
        bit   seen;
        exp_t m;
        sel_r  = sel;
        settle = sel ? 0 : 4;
        sb_q.push_back(model(sel ? gate_b : gate_a, code, settle));
        if (sel) begin start_b = 1'b1; exp_b = code; end
        else     begin start_a = 1'b1; exp_a = code; end
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc <= 400) begin
            if (cur_done) begin
                seen = 1'b1;
            end else begin
                chk("busy_during_sweep", cur_busy, 1);
                chk("dut_in_row", cur_in, (cyc - 1) / (settle + 1));
                if (cyc == 1) begin
                    chk("observed_cleared", cur_obs, 0);
                    chk("pass_cleared", cur_pass, 0);
                end
                if (poke && cyc == 3) begin
                    if (sel) begin start_b = 1'b1; exp_b = ~code; end
                    else     begin start_a = 1'b1; exp_a = ~code; end
                end
                tick();
                start_a = 1'b0;
                start_b = 1'b0;
                cyc++;
            end
        end
        if (!seen) begin
            chk("done_timeout", 0, 1);
            void'(sb_q.pop_front());
        end else begin
            m = sb_q.pop_front();
            chk("done_cycle", cyc, m.done_cyc);
            chk("busy_at_done", cur_busy, 0);
            chk("pass", cur_pass, m.pass);
            chk("observed", cur_obs, m.obs);
            chk("first_fail", cur_ff, m.ff);
            tick();
            chk("done_single_pulse", cur_done, 0);
            chk("busy_after_done", cur_busy, 0);
            chk("observed_held", cur_obs, m.obs);
            chk("pass_held", cur_pass, m.pass);
            chk("first_fail_held", cur_ff, m.ff);
        end
    endtask

    initial begin
        bit any_done;
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        exp_a = 8'h00;  exp_b = 8'h00;
        gate_a = 8'h87; gate_b = 8'h87;
        sel_r = 1'b0;
        tick();
        tick();
        chk("rst_dut_in", dut_in_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_observed", obs_a, 0);
        chk("rst_first_fail", ff_a, 0);
        chk("rst_busy_b", busy_b, 0);
        rst = 1'b0;
        tick();

        run_sweep(1'b0, 8'h87, 1'b0);
        run_sweep(1'b0, 8'h86, 1'b0);
        run_sweep(1'b0, 8'h07, 1'b0);
        gate_a = 8'h96;
        run_sweep(1'b0, 8'h96, 1'b0);
        run_sweep(1'b0, 8'h94, 1'b0);
        gate_a = 8'h87;

        // Reset pulsed in cycle 17 of a sweep.
        sel_r = 1'b0;
        start_a = 1'b1;
        exp_a = 8'h87;
        tick();
        start_a = 1'b0;
        repeat (16) tick();
        chk("busy_before_mid_rst", busy_a, 1);
        chk("dut_in_before_mid_rst", dut_in_a, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_dut_in", dut_in_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_done", done_a, 0);
        chk("mid_rst_pass", pass_a, 0);
        chk("mid_rst_observed", obs_a, 0);
        chk("mid_rst_first_fail", ff_a, 0);
        any_done = 1'b0;
        repeat (60) begin
            tick();
            if (done_a || busy_a) any_done = 1'b1;
        end
        chk("no_done_after_rst", any_done, 0);
        run_sweep(1'b0, 8'h87, 1'b0);

        // start coincident with reset is dropped.
        rst = 1'b1;
        start_a = 1'b1;
        exp_a = 8'h87;
        tick();
        rst = 1'b0;
        start_a = 1'b0;
        chk("start_with_rst_busy", busy_a, 0);
        tick();
        chk("start_with_rst_busy_later", busy_a, 0);
        chk("start_with_rst_done", done_a, 0);

        run_sweep(1'b1, 8'h87, 1'b1);
        run_sweep(1'b1, 8'h3c, 1'b1);
        run_sweep(1'b1, 8'h86, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
